ob_readback_serializer: RTL and testbench

Downstream readout stage for the systolic-array test chip. After the matrix-mult wrapper reports `done_o`, this block reads a programmable range of rows from the output buffer SRAM. Each `WIDTH*COL`-bit word is down-serialised into `OUT_WIDTH`-bit beats and streamed to the pads over a valid/ready handshake. It owns the output-buffer memory port during readback; the test harness muxes that port between it and the wrapper.

---
 rtl/ob_readback_pkg.sv | 25 ++
 rtl/ob_word_serializer.sv | 82 ++++++++
 rtl/ob_readback_serializer.sv | 177 +++++++++++++++++
 tb/tb_ob_readback_serializer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_readback_pkg.sv
// Shared types and elaboration helpers for the output-buffer readback path.
//   ob_rd_state_e : readback FSM state encoding
//   ob_beats()    : beats per memory word (memory word width / beat width)
//   ob_cnt_w()    : counter width able to index 0..n-1 (never narrower than 1)
package ob_readback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } ob_rd_state_e;

    // Number of OUT_WIDTH beats that make up one memory word.
    function automatic int unsigned ob_beats(input int unsigned mem_w,
                                             input int unsigned out_w);
        return mem_w / out_w;
    endfunction

    // Width of a counter indexing n items; a single item still needs one bit.
    function automatic int unsigned ob_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ob_word_serializer.sv
// Parallel-load shift register that splits one memory word into OUT_W beats,
// least-significant slice first, presented on a valid/ready handshake.
// Ports:
//   clk_i, rstn_i     : clock, async active-low reset
//   i_load            : load i_data, restart the beat counter, raise valid
//   i_data            : memory word to serialise
//   i_last_word       : the loaded word is the final word of the readback
//   i_ready           : consumer ready
//   o_data            : current beat (registered shift-register slice)
//   o_valid           : beat valid (registered, independent of i_ready)
//   o_last            : current beat is the last beat of the last word
//   o_word_done_c     : handshake of the final beat of the word (combinational)
module ob_word_serializer
    import ob_readback_pkg::*;
#(
    parameter int unsigned MEM_W = 32,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             i_load,
    input  logic [MEM_W-1:0] i_data,
    input  logic             i_last_word,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_last,
    output logic             o_word_done_c
);

    localparam int unsigned BEATS  = ob_beats(MEM_W, OUT_W);
    localparam int unsigned BEAT_W = ob_cnt_w(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [MEM_W-1:0]  r_shreg;
    logic [BEAT_W-1:0] r_beat;
    logic              r_valid;
    logic              r_last;
    logic              r_last_word;

    logic              w_fire;
    logic              w_final_beat;
    logic [BEAT_W-1:0] w_beat_inc;

    assign w_fire       = r_valid & i_ready;
    assign w_final_beat = (r_beat == LAST_BEAT);
    assign w_beat_inc   = r_beat + BEAT_W'(1);

    // Shift register, beat counter and registered handshake flags.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_shreg     <= '0;
            r_beat      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_last_word <= 1'b0;
        end else if (i_load) begin
            r_shreg     <= i_data;
            r_beat      <= '0;
            r_valid     <= 1'b1;
            r_last_word <= i_last_word;
            // Single-beat words are already on their last beat at load time.
            r_last      <= i_last_word & (LAST_BEAT == '0);
        end else if (w_fire) begin
            r_shreg <= r_shreg >> OUT_W;
            r_beat  <= w_beat_inc;
            if (w_final_beat) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                // Flag precomputed one beat ahead so o_last stays registered.
                r_last  <= r_last_word & (w_beat_inc == LAST_BEAT);
            end
        end
    end

    assign o_data        = r_shreg[OUT_W-1:0];
    assign o_valid       = r_valid;
    assign o_last        = r_last;
    assign o_word_done_c = w_fire & w_final_beat;

endmodule

// File: rtl/ob_readback_serializer.sv
// Reads a programmable range of output-buffer words after the array finishes
// and streams each word to the pads as OUT_WIDTH-bit beats.
// Ports:
//   clk_i, rstn_i        : clock, async active-low reset
//   start_i              : rising edge starts a readback (ignored while busy)
//   base_addr_i          : first word address, sampled on the start edge
//   num_words_i          : word count, sampled on the start edge (0 legal)
//   ob_mem_cenb_o        : output-buffer enable, active low (READ only)
//   ob_mem_wenb_o        : output-buffer write enable, tied inactive
//   ob_mem_addr_o        : output-buffer read address
//   ob_mem_data_i        : read data, one cycle after the enabled edge
//   rd_data_o            : beat data
//   rd_valid_o           : beat valid
//   rd_ready_i           : consumer ready
//   rd_last_o            : final beat of final word
//   busy_o               : readback in progress
//   done_o               : idle with readback complete
module ob_readback_serializer
    import ob_readback_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned COL       = 4,
    parameter int unsigned O_SIZE    = 256,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               start_i,
    input  logic [$clog2(O_SIZE)-1:0]          base_addr_i,
    input  logic [$clog2(O_SIZE):0]            num_words_i,
    output logic                               ob_mem_cenb_o,
    output logic                               ob_mem_wenb_o,
    output logic [$clog2(O_SIZE)-1:0]          ob_mem_addr_o,
    input  logic [WIDTH*COL-1:0]               ob_mem_data_i,
    output logic [OUT_WIDTH-1:0]               rd_data_o,
    output logic                               rd_valid_o,
    input  logic                               rd_ready_i,
    output logic                               rd_last_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int unsigned MEM_C_WIDTH = WIDTH * COL;
    localparam int unsigned BEATS       = ob_beats(MEM_C_WIDTH, OUT_WIDTH);
    localparam int unsigned ADDR_W      = $clog2(O_SIZE);
    localparam int unsigned CNT_W       = ADDR_W + 1;

    // A memory word must split into a whole number of beats.
    if ((MEM_C_WIDTH % OUT_WIDTH) != 0 || BEATS == 0) begin : g_width_check
        $error("ob_readback_serializer: WIDTH*COL must be a multiple of OUT_WIDTH");
    end

    ob_rd_state_e      r_state;
    ob_rd_state_e      w_state_next;

    logic              r_start_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  w_rem_next;
    logic              r_cenb;
    logic              w_cenb_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_busy;
    logic              w_busy_next;

    logic              w_start_edge;
    logic              w_load;
    logic              w_last_word;
    logic              w_word_done;

    assign w_start_edge = start_i & ~r_start_d;
    assign w_last_word  = (r_remaining == CNT_W'(1));

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-value logic for the control registers.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_rem_next   = r_remaining;
        w_done_next  = r_done;
        w_load       = 1'b0;

        case (r_state)
            IDLE: begin
                // A zero-count start dips done for the single cycle after the edge.
                w_done_next = 1'b1;
                if (w_start_edge) begin
                    w_done_next = 1'b0;
                    if (num_words_i != '0) begin
                        w_addr_next  = base_addr_i;
                        w_rem_next   = num_words_i;
                        w_state_next = READ;
                    end
                end
            end
            READ: begin
                w_state_next = LATCH;
            end
            LATCH: begin
                w_load       = 1'b1;
                w_addr_next  = (r_addr == ADDR_W'(O_SIZE - 1)) ? '0
                                                               : r_addr + ADDR_W'(1);
                w_rem_next   = r_remaining - CNT_W'(1);
                w_state_next = SEND;
            end
            SEND: begin
                if (w_word_done) begin
                    if (r_remaining != '0) begin
                        w_state_next = READ;
                    end else begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Registered outputs are computed from the state being entered.
        w_cenb_next = (w_state_next != READ);
        w_busy_next = (w_state_next != IDLE);
    end

    // Control datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_start_d   <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_cenb      <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_start_d   <= start_i;
            r_addr      <= w_addr_next;
            r_remaining <= w_rem_next;
            r_cenb      <= w_cenb_next;
            r_done      <= w_done_next;
            r_busy      <= w_busy_next;
        end
    end

    ob_word_serializer #(
        .MEM_W (MEM_C_WIDTH),
        .OUT_W (OUT_WIDTH)
    ) u_word_serializer (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .i_load        (w_load),
        .i_data        (ob_mem_data_i),
        .i_last_word   (w_last_word),
        .i_ready       (rd_ready_i),
        .o_data        (rd_data_o),
        .o_valid       (rd_valid_o),
        .o_last        (rd_last_o),
        .o_word_done_c (w_word_done)
    );

    assign ob_mem_cenb_o = r_cenb;
    assign ob_mem_wenb_o = 1'b1;
    assign ob_mem_addr_o = r_addr;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule

// File: tb/tb_ob_readback_serializer.sv
// Directed and randomized readbacks checked against a queue-based model of
// the expected beat stream, read addresses and handshake timing.
module tb_ob_readback_serializer;

    localparam int BEATS  = 4;
    localparam int O_SIZE = 256;
    localparam int LIMIT  = 3000;

    logic        clk_i       = 1'b0;
    logic        rstn_i      = 1'b0;
    logic        start_i     = 1'b0;
    logic [7:0]  base_addr_i = '0;
    logic [8:0]  num_words_i = '0;
    logic        ob_mem_cenb_o;
    logic        ob_mem_wenb_o;
    logic [7:0]  ob_mem_addr_o;
    logic [31:0] ob_mem_data_i = '0;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i  = 1'b0;
    logic        rd_last_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    ob_readback_serializer #(
        .WIDTH     (8),
        .COL       (4),
        .O_SIZE    (O_SIZE),
        .OUT_WIDTH (8)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_words_i   (num_words_i),
        .ob_mem_cenb_o (ob_mem_cenb_o),
        .ob_mem_wenb_o (ob_mem_wenb_o),
        .ob_mem_addr_o (ob_mem_addr_o),
        .ob_mem_data_i (ob_mem_data_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_last_o     (rd_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // Output-buffer SRAM: data appears one cycle after an enabled edge.
    logic [31:0] mem [0:O_SIZE-1];
    always @(posedge clk_i) begin
        if (!ob_mem_cenb_o) ob_mem_data_i <= mem[ob_mem_addr_o];
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         t;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    rel;
    beat_t got_q[$];
    beat_t exp_q[$];
    int    rd_addr_q[$];
    int    rd_t_q[$];
    int    first_valid_t, done_rise_t, done_low_cnt, valid_cnt, unstable, hold_cnt;
    int    ready_mode, inject_at, reset_at;
    bit    aborted, injected, seen_done_low;
    logic       prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream: every word of the range, low byte first.
    task automatic build_exp(input int base, input int n);
        exp_q.delete();
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < BEATS; b++) begin
                beat_t e;
                e.data = 8'(mem[(base + w) % O_SIZE] >> (8 * b));
                e.last = (w == n - 1) && (b == BEATS - 1);
                e.t    = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " cenb"},  64'(ob_mem_cenb_o), 64'd1);
        check({tag, " wenb"},  64'(ob_mem_wenb_o), 64'd1);
        check({tag, " addr"},  64'(ob_mem_addr_o), 64'd0);
        check({tag, " data"},  64'(rd_data_o),     64'd0);
        check({tag, " valid"}, 64'(rd_valid_o),    64'd0);
        check({tag, " last"},  64'(rd_last_o),     64'd0);
        check({tag, " busy"},  64'(busy_o),        64'd0);
        check({tag, " done"},  64'(done_o),        64'd1);
    endtask

    // One cycle: drive inputs at the falling edge, then record what the DUT shows.
    task automatic step();
        beat_t g;
        @(negedge clk_i);
        rel++;
        start_i = 1'b0;
        if (inject_at >= 0 && !injected && rd_valid_o && got_q.size() == inject_at) begin
            start_i     = 1'b1;
            base_addr_i = 8'($urandom_range(0, 255));
            num_words_i = 9'($urandom_range(1, 8));
            injected    = 1'b1;
        end
        if (reset_at >= 0 && rd_valid_o && got_q.size() == reset_at) begin
            rstn_i = 1'b0;
            #1;
            check_reset_values("midop_reset");
            aborted = 1'b1;
            return;
        end
        case (ready_mode)
            1: rd_ready_i = ($urandom_range(0, 3) != 0);
            2: begin
                if (rd_valid_o && got_q.size() == 2 && hold_cnt < 5 && exp_q.size() > 2) begin
                    rd_ready_i = 1'b0;
                    hold_cnt++;
                    check("hold_data", 64'(rd_data_o), 64'(exp_q[2].data));
                end else begin
                    rd_ready_i = 1'b1;
                end
            end
            default: rd_ready_i = 1'b1;
        endcase
        if (!ob_mem_cenb_o) begin
            rd_addr_q.push_back(int'(ob_mem_addr_o));
            rd_t_q.push_back(rel);
        end
        if (rd_valid_o) begin
            valid_cnt++;
            if (first_valid_t < 0) first_valid_t = rel;
        end
        if (prev_valid && !prev_ready &&
            (!rd_valid_o || rd_data_o !== prev_data || rd_last_o !== prev_last))
            unstable++;
        if (rd_valid_o && rd_ready_i) begin
            g.data = rd_data_o;
            g.last = rd_last_o;
            g.t    = rel;
            got_q.push_back(g);
        end
        if (!done_o) begin
            done_low_cnt++;
            seen_done_low = 1'b1;
        end else if (seen_done_low && done_rise_t < 0) begin
            done_rise_t = rel;
        end
        prev_valid = rd_valid_o;
        prev_ready = rd_ready_i;
        prev_data  = rd_data_o;
        prev_last  = rd_last_o;
    endtask

    task automatic run(input int base, input int n, input int mode);
        got_q.delete();
        rd_addr_q.delete();
        rd_t_q.delete();
        first_valid_t = -1;
        done_rise_t   = -1;
        done_low_cnt  = 0;
        valid_cnt     = 0;
        unstable      = 0;
        hold_cnt      = 0;
        aborted       = 1'b0;
        injected      = 1'b0;
        seen_done_low = 1'b0;
        prev_valid    = 1'b0;
        prev_ready    = 1'b0;
        ready_mode    = mode;
        build_exp(base, n);
        @(negedge clk_i);
        base_addr_i = 8'(base);
        num_words_i = 9'(n);
        start_i     = 1'b1;
        rd_ready_i  = 1'b1;
        rel         = 0;
        do step(); while (!aborted && !(rel > 2 && done_o && !busy_o) && rel < LIMIT);
        if (!aborted) begin
            n_checks++;
            assert (rel < LIMIT) else begin
                n_fail++;
                $error("FAIL timeout: readback base=%0d n=%0d still busy after %0d cycles", base, n, rel);
            end
        end
    endtask

    task automatic verify(input int base, input int n, input bit timing);
        int nb;
        check("read_count", 64'(rd_addr_q.size()), 64'(n));
        for (int i = 0; i < rd_addr_q.size() && i < n; i++) begin
            check("read_addr", 64'(rd_addr_q[i]), 64'((base + i) % O_SIZE));
            if (timing) check("read_cycle", 64'(rd_t_q[i]), 64'(1 + i * (BEATS + 2)));
        end
        check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++) begin
            check("beat_data", 64'(got_q[i].data), 64'(exp_q[i].data));
            check("beat_last", 64'(got_q[i].last), 64'(exp_q[i].last));
            if (timing)
                check("beat_cycle", 64'(got_q[i].t),
                      64'(3 + (i / BEATS) * (BEATS + 2) + (i % BEATS)));
        end
        check("stable_under_backpressure", 64'(unstable), 64'd0);
        check("done_low_cycles", 64'(done_low_cnt), 64'(done_rise_t - 1));
        check("end_done", 64'(done_o), 64'd1);
        check("end_valid", 64'(rd_valid_o), 64'd0);
        if (n == 0) begin
            check("zero_done_rise", 64'(done_rise_t), 64'd2);
            check("zero_valid", 64'(valid_cnt), 64'd0);
        end else begin
            check("first_valid_cycle", 64'(first_valid_t), 64'd3);
            if (got_q.size() > 0) begin
                check("done_after_last", 64'(done_rise_t), 64'(got_q[got_q.size()-1].t + 1));
                if (timing && rd_t_q.size() > 0)
                    check("total_cycles", 64'(got_q[got_q.size()-1].t - rd_t_q[0] + 1),
                          64'(n * (BEATS + 2)));
            end
        end
    endtask

    initial begin
        inject_at = -1;
        reset_at  = -1;
        for (int i = 0; i < O_SIZE; i++) mem[i] = $urandom;
        mem[5]   = 32'h44332211;
        mem[254] = 32'hA3A2A1A0;
        mem[255] = 32'hB3B2B1B0;
        mem[0]   = 32'hC3C2C1C0;

        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Single word, ready held high.
        run(5, 1, 0);
        verify(5, 1, 1);

        // Address wrap across the top of the buffer.
        run(254, 3, 0);
        verify(254, 3, 1);

        // Consumer stalls for five cycles on the third beat.
        run(5, 1, 2);
        verify(5, 1, 0);
        check("hold_cycles", 64'(hold_cnt), 64'd5);

        // Zero-length readback.
        run(10, 0, 0);
        verify(10, 0, 0);

        // Second start edge while busy is ignored.
        inject_at = 1;
        run(20, 2, 0);
        verify(20, 2, 1);
        check("inject_seen", 64'(injected), 64'd1);
        inject_at = -1;

        // Reset during the second beat of the second word, then a fresh readback.
        reset_at = 5;
        run(40, 3, 0);
        check("reset_hit", 64'(aborted), 64'd1);
        reset_at = -1;
        @(negedge clk_i);
        rstn_i = 1'b1;
        run(100, 2, 1);
        verify(100, 2, 0);

        // Randomized ranges with random backpressure.
        for (int k = 0; k < 8; k++) begin
            int b, n;
            b = $urandom_range(0, O_SIZE - 1);
            n = $urandom_range(0, 6);
            for (int w = 0; w < n; w++) mem[(b + w) % O_SIZE] = $urandom;
            run(b, n, 1);
            verify(b, n, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
